alu_arbiter: RTL and testbench

//  Shares one combinational ALU (opcode/A/B -> result/cout/borrow) between two requesters.

---
 rtl/alu_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. A round-robin arbiter
// accepts one request at a time over a valid/ready handshake, registers the
// operands towards the ALU, holds them for ALU_LAT cycles, then captures the
// ALU outputs into a response register with valid/ready backpressure.
// Operations are serialised: IDLE -> EXEC -> RESP -> IDLE, with no queueing.
//
// Optional build macro: ALU_ARB_STATS_EN adds per-requester grant counters
// (gnt_cnt0/gnt_cnt1). Without it those ports and counters do not exist.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   req{0,1}_valid/_ready      request handshake (valid & ready = accept)
//   req{0,1}_opcode/_a/_b      request operation and operands
//   rsp_valid/rsp_ready        response handshake (valid & ready = pop)
//   rsp_id                     requester that owns the response
//   rsp_result/cout/borrow     captured ALU outputs
//   alu_opcode/alu_a/alu_b     registered operands to the ALU
//   alu_result/cout/borrow     combinational ALU outputs
//   gnt_cnt0/gnt_cnt1          grant counters (ALU_ARB_STATS_EN only)
//
// ALU_LAT is legal in 1..15.
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned OPW     = 3,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_borrow,

`ifdef ALU_ARB_STATS_EN
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
`endif

    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_borrow
);

    localparam int unsigned           WAIT_W = 4;
    localparam logic [WAIT_W-1:0]     LAT_M1 = WAIT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_d;

    logic               r_last_grant;
    logic [WAIT_W-1:0]  r_wait;

    logic [OPW-1:0]     r_alu_opcode;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;

    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_result;
    logic               r_rsp_cout;
    logic               r_rsp_borrow;

    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_accept;
    logic               w_sel;
    logic               w_capture;
    logic               w_pop;

    // Round-robin grant: on contention the requester that did not win last
    // time gets it. r_last_grant resets to 1 so requester 0 wins first.
    always_comb begin
        w_gnt0     = req0_valid & (~req1_valid | r_last_grant);
        w_gnt1     = req1_valid & (~req0_valid | ~r_last_grant);
        req0_ready = (r_state == StIdle) & w_gnt0;
        req1_ready = (r_state == StIdle) & w_gnt1;
        w_accept   = req0_ready | req1_ready;
        w_sel      = req1_ready;
    end

    // Next-state and control strobes.
    always_comb begin
        w_state_d = r_state;
        w_capture = 1'b0;
        w_pop     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = StExec;
                end
            end
            StExec: begin
                if (r_wait == '0) begin
                    w_capture = 1'b1;
                    w_state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    w_pop     = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Operand, wait-counter and arbitration history registers. The ALU
    // operands only change on accept, so they hold the last operation in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_id     <= 1'b0;
            r_last_grant <= 1'b1;
            r_wait       <= '0;
        end else if (w_accept) begin
            r_alu_opcode <= w_sel ? req1_opcode : req0_opcode;
            r_alu_a      <= w_sel ? req1_a      : req0_a;
            r_alu_b      <= w_sel ? req1_b      : req0_b;
            r_rsp_id     <= w_sel;
            r_last_grant <= w_sel;
            r_wait       <= LAT_M1;
        end else if ((r_state == StExec) && (r_wait != '0)) begin
            r_wait <= r_wait - 1'b1;
        end
    end

    // Response register: loaded once per operation, held until popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_cout   <= 1'b0;
            r_rsp_borrow <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= alu_result;
            r_rsp_cout   <= alu_cout;
            r_rsp_borrow <= alu_borrow;
        end else if (w_pop) begin
            r_rsp_valid  <= 1'b0;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] r_gnt_cnt0;
    logic [CNT_W-1:0] r_gnt_cnt1;

    // Free-running grant counters; natural wrap at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else begin
            if (req0_ready) begin
                r_gnt_cnt0 <= r_gnt_cnt0 + CNT_W'(1);
            end
            if (req1_ready) begin
                r_gnt_cnt1 <= r_gnt_cnt1 + CNT_W'(1);
            end
        end
    end

    assign gnt_cnt0 = r_gnt_cnt0;
    assign gnt_cnt1 = r_gnt_cnt1;
`endif

    assign alu_opcode = r_alu_opcode;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_cout   = r_rsp_cout;
    assign rsp_borrow = r_rsp_borrow;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. An ALU stub (result = A+B, cout = carry,
// borrow = A<B, opcode ignored) closes the loop. A small reference model keeps
// the round-robin history and grant counts and computes every expected value
// from the operands the model says were granted.
// ---------------------------------------------------------------------------
module tb_alu_arbiter #(
    parameter int unsigned ALU_LAT = 1
);
    localparam int unsigned WIDTH = 4;
    localparam int unsigned OPW   = 3;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [OPW-1:0]   req0_opcode, req1_opcode;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_borrow;
    logic [WIDTH-1:0] rsp_result;
    logic [OPW-1:0]   alu_opcode;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic             alu_cout, alu_borrow;
`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int          m_last = 1;
    int unsigned m_cnt0 = 0;
    int unsigned m_cnt1 = 0;

    alu_arbiter #(
        .WIDTH   (WIDTH),
        .OPW     (OPW),
        .ALU_LAT (ALU_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opcode (req0_opcode),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opcode (req1_opcode),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_cout    (rsp_cout),
        .rsp_borrow  (rsp_borrow),
`ifdef ALU_ARB_STATS_EN
        .gnt_cnt0    (gnt_cnt0),
        .gnt_cnt1    (gnt_cnt1),
`endif
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .alu_borrow  (alu_borrow)
    );

    // ALU stub.
    assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_borrow             = (alu_a < alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt();
`ifdef ALU_ARB_STATS_EN
        check("gnt_cnt0", 32'(gnt_cnt0), m_cnt0 % 256);
        check("gnt_cnt1", 32'(gnt_cnt1), m_cnt1 % 256);
`endif
    endtask

    // One complete operation: present requests, check the grant the model
    // predicts, the operand hold, the response timing/contents and the pop.
    // hold = cycles rsp_ready stays low after the response appears.
    // keep = leave the valids asserted after accept.
    task automatic run_op(input bit v0, input bit v1,
                          input int op0, input int a0, input int b0,
                          input int op1, input int a1, input int b1,
                          input int hold, input bit keep);
        int g, eop, ea, eb, sum;
        @(negedge clk);
        req0_valid  = v0;
        req1_valid  = v1;
        req0_opcode = OPW'(op0);
        req0_a      = WIDTH'(a0);
        req0_b      = WIDTH'(b0);
        req1_opcode = OPW'(op1);
        req1_a      = WIDTH'(a1);
        req1_b      = WIDTH'(b1);
        rsp_ready   = (hold == 0);
        #1;
        if (v0 && v1) g = (m_last == 1) ? 0 : 1;
        else          g = v0 ? 0 : 1;
        check("req0_ready", 32'(req0_ready), 32'(g == 0));
        check("req1_ready", 32'(req1_ready), 32'(g == 1));
        m_last = g;
        eop = (g == 0) ? op0 : op1;
        ea  = (g == 0) ? a0  : a1;
        eb  = (g == 0) ? b0  : b1;
        sum = ea + eb;
        if (g == 0) m_cnt0++;
        else        m_cnt1++;

        @(posedge clk);
        #1;
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        check("alu_opcode", 32'(alu_opcode), eop);
        check("alu_a", 32'(alu_a), ea);
        check("alu_b", 32'(alu_b), eb);
        check_cnt();

        for (int k = 1; k <= int'(ALU_LAT); k++) begin
            @(posedge clk);
            #1;
            check("busy_ready", 32'({req0_ready, req1_ready}), 0);
            check("alu_a_hold", 32'(alu_a), ea);
            check("alu_b_hold", 32'(alu_b), eb);
            if (k < int'(ALU_LAT)) begin
                check("rsp_valid_early", 32'(rsp_valid), 0);
            end else begin
                check("rsp_valid", 32'(rsp_valid), 1);
                check("rsp_result", 32'(rsp_result), sum % 16);
                check("rsp_cout", 32'(rsp_cout), 32'(sum >= 16));
                check("rsp_borrow", 32'(rsp_borrow), 32'(ea < eb));
                check("rsp_id", 32'(rsp_id), g);
            end
        end

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_result", 32'(rsp_result), sum % 16);
            check("hold_cout", 32'(rsp_cout), 32'(sum >= 16));
            check("hold_ready", 32'({req0_ready, req1_ready}), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pop_valid", 32'(rsp_valid), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        m_last = 1;
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    initial begin
        reset       = 1'b1;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_opcode = '0;
        req1_opcode = '0;
        req0_a      = '0;
        req0_b      = '0;
        req1_a      = '0;
        req1_b      = '0;
        rsp_ready   = 1'b1;

        // Reset values.
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp", 32'({rsp_id, rsp_result, rsp_cout, rsp_borrow}), 0);
        check("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 0);
        check_cnt();
        @(negedge clk);
        reset = 1'b0;

        // Directed single-requester operations.
        run_op(1, 0, 0, 4, 3, 0, 0, 0, 0, 0);
        run_op(0, 1, 0, 0, 0, 5, 6, 7, 0, 0);

        // Continuous contention: expect alternation starting with req0.
        for (int i = 0; i < 4; i++) begin
            run_op(1, 1, 1, 2 + i, 1, 2, 9, i, 0, (i != 3));
        end

        // Backpressure with carry out.
        run_op(1, 0, 3, 15, 1, 0, 0, 0, 10, 0);

        // No requests: stays idle, nothing granted.
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", 32'({req0_ready, req1_ready}), 0);
            check("idle_rsp_valid", 32'(rsp_valid), 0);
        end

        // Reset during EXEC after a req0 grant: dropped, history restored.
        @(negedge clk);
        req0_valid = 1'b1;
        req0_a     = 4'd9;
        req0_b     = 4'd2;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        reset      = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        check("midrst_ready", 32'({req0_ready, req1_ready}), 0);
        check("midrst_alu_a", 32'(alu_a), 0);
        @(negedge clk);
        reset  = 1'b0;
        m_last = 1;
        m_cnt0 = 0;
        m_cnt1 = 0;
        repeat (int'(ALU_LAT) + 1) begin
            @(posedge clk);
            #1;
            check("midrst_no_rsp", 32'(rsp_valid), 0);
        end
        run_op(1, 1, 2, 1, 1, 4, 3, 3, 0, 0);

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_op(v0, v1,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 0);
        end

        // 256 req0 grants from reset: counter wraps back to zero.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_op(1, 0, i % 8, i % 16, (i / 16) % 16, 0, 0, 0, 0, 0);
        end
        check_cnt();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
